// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;

   localparam int N_DEF    = 32;
   localparam int ADDR_DEF = 5;
   localparam int NUM_WR   = 2;

   localparam logic [ADDR_DEF-1:0] ZERO_ADDR = '0;

   typedef logic [N_DEF-1:0]    word_t;
   typedef logic [ADDR_DEF-1:0] addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by reserve at issue, cleared by either write-back lane.
// A reserve on the same edge as a release of that register leaves it busy.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR     = ADDR_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   reserve_i,
   input  logic [ADDR-1:0]        reserve_addr_i,
   input  logic [NUM_WR-1:0]      release_i,
   input  logic [NUM_WR*ADDR-1:0] release_addr_i,
   output logic [2**ADDR-1:0]     busy_o
);

   localparam int DEPTH = 2**ADDR;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // next busy vector: reserve dominates release, register 0 pinned when hardwired
   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < DEPTH; k++) begin
         busy_d[k] = ((ZERO_REG != 0) && (k == 0)) ? 1'b0 :
                     (reserve_i && (reserve_addr_i == ADDR'(k))) ? 1'b1 :
                     ((release_i[0] && (release_addr_i[0 +: ADDR] == ADDR'(k))) ||
                      (release_i[1] && (release_addr_i[ADDR +: ADDR] == ADDR'(k)))) ? 1'b0 :
                     busy_q[k];
      end
   end

   // busy state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write lanes
// (lane 1 wins on collision), optional write-to-read bypass and busy scoreboard.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int ADDR     = ADDR_DEF,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_WR-1:0]      Reg_Write_i,
   input  logic [NUM_WR*ADDR-1:0] Write_Register_i,
   input  logic [NUM_WR*N-1:0]    Write_Data_i,
   input  logic                   Reserve_i,
   input  logic [ADDR-1:0]        Reserve_Register_i,
   input  logic [NUM_RD*ADDR-1:0] Read_Register_i,
   output logic [NUM_RD*N-1:0]    Read_Data_o,
   output logic [NUM_RD-1:0]      Read_Busy_o
);

   localparam int DEPTH = 2**ADDR;
   localparam bit BYP   = (BYPASS != 0);
   localparam bit ZR    = (ZERO_REG != 0);

   logic [N-1:0]     mem_q [DEPTH];
   logic [N-1:0]     mem_d [DEPTH];
   logic [DEPTH-1:0] busy_s;

   logic [ADDR-1:0]   wa0_s, wa1_s;
   logic [N-1:0]      wd0_s, wd1_s;
   logic              reserve_s;
   logic [NUM_WR-1:0] release_s;

   assign wa0_s = Write_Register_i[0 +: ADDR];
   assign wa1_s = Write_Register_i[ADDR +: ADDR];
   assign wd0_s = Write_Data_i[0 +: N];
   assign wd1_s = Write_Data_i[N +: N];

   // writes and reserves aimed at a hardwired zero register are dropped before they reach state
   assign release_s[0] = Reg_Write_i[0] && !(ZR && (wa0_s == {ADDR{1'b0}}));
   assign release_s[1] = Reg_Write_i[1] && !(ZR && (wa1_s == {ADDR{1'b0}}));
   assign reserve_s    = Reserve_i && !(ZR && (Reserve_Register_i == {ADDR{1'b0}}));

   // next storage contents: lane 1 has priority over lane 0 on the same register
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         mem_d[k] = (release_s[1] && (wa1_s == ADDR'(k))) ? wd1_s :
                    (release_s[0] && (wa0_s == ADDR'(k))) ? wd0_s :
                    mem_q[k];
      end
   end

   // storage array with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= mem_d[k];
         end
      end
   end

   rf_scoreboard #(
      .ADDR     (ADDR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk            (clk),
      .reset          (reset),
      .reserve_i      (reserve_s),
      .reserve_addr_i (Reserve_Register_i),
      .release_i      (release_s),
      .release_addr_i (Write_Register_i),
      .busy_o         (busy_s)
   );

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR-1:0] ra_s;
      logic            hit0_s, hit1_s, zero_s;
      logic [N-1:0]    rd_data_s;
      logic            rd_busy_s;

      assign ra_s   = Read_Register_i[r*ADDR +: ADDR];
      assign hit0_s = BYP && Reg_Write_i[0] && (wa0_s == ra_s);
      assign hit1_s = BYP && Reg_Write_i[1] && (wa1_s == ra_s);
      assign zero_s = ZR && (ra_s == {ADDR{1'b0}});

      // read mux: zero register, then forwarded write data, then stored value
      always_comb begin
         rd_data_s = zero_s ? {N{1'b0}} :
                     hit1_s ? wd1_s :
                     hit0_s ? wd0_s :
                     mem_q[ra_s];
         rd_busy_s = (zero_s || hit0_s || hit1_s) ? 1'b0 : busy_s[ra_s];
      end

      assign Read_Data_o[r*N +: N] = rd_data_s;
      assign Read_Busy_o[r]        = rd_busy_s;
   end

endmodule
